// File: rtl/imm_decode_stage.sv
// RV32I immediate-decode pipeline stage: decodes the immediate and format of an
// instruction, then holds it in a two-entry (output register + skid) elastic buffer.
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{
        instr:   32'h0000_0000,
        imm:     {XLEN{1'b0}},
        fmt:     3'd0,
        illegal: 1'b0
    };

    // Builds a complete entry from a raw instruction; bit 31 is always the sign source.
    function automatic entry_t decode_entry(input logic [31:0] instr);
        entry_t e;
        e.instr   = instr;
        e.imm     = {XLEN{1'b0}};
        e.fmt     = FMT_NONE;
        e.illegal = 1'b0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                e.imm = {{20{instr[31]}}, instr[31:20]};
                e.fmt = FMT_I;
            end
            OP_STORE: begin
                e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                e.fmt = FMT_S;
            end
            OP_BRANCH: begin
                e.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
                e.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                e.imm = {instr[31:12], 12'h000};
                e.fmt = FMT_U;
            end
            OP_JAL: begin
                e.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
                e.fmt = FMT_J;
            end
            default: begin
                e.imm     = {XLEN{1'b0}};
                e.fmt     = FMT_NONE;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;

    entry_t new_entry_s;
    logic   accept_s;
    logic   out_load_s;

    assign new_entry_s = decode_entry(in_instr);
    assign in_ready    = ~skid_valid_q & ~flush;
    assign accept_s    = in_valid & in_ready;
    // Output register may be overwritten when empty or being consumed this cycle.
    assign out_load_s  = ~out_valid_q | out_ready;

    // Next-state for the output register and skid entry; flush overrides everything.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_d        = ENTRY_RST;
            out_valid_d  = 1'b0;
            skid_d       = ENTRY_RST;
            skid_valid_d = 1'b0;
        end else if (out_load_s) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_d        = new_entry_s;
                out_valid_d  = 1'b1;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_d       = new_entry_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers with asynchronous clear of both entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= ENTRY_RST;
            out_valid_q  <= 1'b0;
            skid_q       <= ENTRY_RST;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: decode vector table through a scoreboard
// plus hand sequences for latency, backpressure, flush and reset.
module tb_imm_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    vec_t tbl [15];
    vec_t sb [$];
    vec_t cur_exp;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop on consume, push on accept, drop everything on flush/reset.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL sb_unexpected: got out_instr %h expected no output", out_instr);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("sb_instr", out_instr, e.instr);
                    chk("sb_imm", out_imm, e.imm);
                    chk("sb_fmt", {29'd0, out_fmt}, {29'd0, e.fmt});
                    chk("sb_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end else begin
            sb.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int idx);
        in_valid = 1'b1;
        in_instr = tbl[idx].instr;
        cur_exp  = tbl[idx];
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        cur_exp   = '{instr: 32'h0, imm: 32'h0, fmt: 3'd0, ill: 1'b0};

        tbl[0]  = '{instr: 32'hFFF00093, imm: 32'hFFFFFFFF, fmt: 3'd0, ill: 1'b0};
        tbl[1]  = '{instr: 32'hFE112E23, imm: 32'hFFFFFFFC, fmt: 3'd1, ill: 1'b0};
        tbl[2]  = '{instr: 32'h123452B7, imm: 32'h12345000, fmt: 3'd3, ill: 1'b0};
        tbl[3]  = '{instr: 32'h0000007F, imm: 32'h00000000, fmt: 3'd7, ill: 1'b1};
        tbl[4]  = '{instr: 32'hFE000EE3, imm: 32'hFFFFFFFC, fmt: 3'd2, ill: 1'b0};
        tbl[5]  = '{instr: 32'h0080006F, imm: 32'h00000008, fmt: 3'd4, ill: 1'b0};
        tbl[6]  = '{instr: 32'hFFFFF06F, imm: 32'hFFFFFFFE, fmt: 3'd4, ill: 1'b0};
        tbl[7]  = '{instr: 32'h7FF00093, imm: 32'h000007FF, fmt: 3'd0, ill: 1'b0};
        tbl[8]  = '{instr: 32'h00412083, imm: 32'h00000004, fmt: 3'd0, ill: 1'b0};
        tbl[9]  = '{instr: 32'h000080E7, imm: 32'h00000000, fmt: 3'd0, ill: 1'b0};
        tbl[10] = '{instr: 32'h00000073, imm: 32'h00000000, fmt: 3'd0, ill: 1'b0};
        tbl[11] = '{instr: 32'h80000097, imm: 32'h80000000, fmt: 3'd3, ill: 1'b0};
        tbl[12] = '{instr: 32'h002080E3, imm: 32'h00000800, fmt: 3'd2, ill: 1'b0};
        tbl[13] = '{instr: 32'h002081B3, imm: 32'h00000000, fmt: 3'd7, ill: 1'b1};
        tbl[14] = '{instr: 32'h7E112FA3, imm: 32'h000007FF, fmt: 3'd1, ill: 1'b0};

        // Reset values while rst_n is held low
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_fmt", {29'd0, out_fmt}, 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single-cycle latency from an empty stage
        step();
        out_ready = 1'b1;
        present(0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_out_imm", out_imm, 32'hFFFFFFFF);
        step();
        drain();

        // Stream the whole table back-to-back with the sink always ready
        for (int i = 0; i < 15; i++) begin
            present(i);
            @(negedge clk);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        drain();

        // Backpressure: fill both entries, then release
        out_ready = 1'b0;
        present(0);
        step();
        present(2);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_out_instr_a", out_instr, 32'hFFF00093);
        repeat (3) step();
        @(negedge clk);
        chk("bp_stable_instr", out_instr, 32'hFFF00093);
        chk("bp_stable_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_stable_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_a", out_instr, 32'hFFF00093);
        @(negedge clk);
        chk("bp_second_b", out_instr, 32'h123452B7);
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_done_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        drain();

        // Flush while both entries are held, with an input offered in the flush cycle
        out_ready = 1'b0;
        present(3);
        step();
        present(4);
        step();
        present(5);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (5) step();
        chk("flush_quiet", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-transfer drops everything
        out_ready = 1'b0;
        present(6);
        step();
        present(7);
        chk("mid_rst_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_instr", out_instr, 32'd0);
        chk("mid_rst_out_imm", out_imm, 32'd0);
        chk("mid_rst_out_fmt", {29'd0, out_fmt}, 32'd0);
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();
        chk("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous discard of all held entries.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  stage can accept; combinational from internal state and flush only.
REQ-007 in_instr  input  32  raw RV32I instruction word.
REQ-008 out_valid  output  1  decoded entry valid.
REQ-009 out_ready  input  1  downstream accepts.
REQ-010 out_instr  output  32  instruction passed through unchanged.
REQ-011 out_imm  output  32  sign-extended immediate.
REQ-012 out_fmt  output  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 7=none.
REQ-013 out_illegal  output  1  opcode not in the decode table.

Function
REQ-014 Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-015 Storage: one output register plus one skid entry; 2 entries maximum.
REQ-016 Latency: an instruction accepted in cycle N SHALL appear on out_* in cycle N+1 when the stage was empty.
REQ-017 in_ready SHALL be 1 iff the skid entry is empty and flush=0.
REQ-018 If the output register holds an entry that is not consumed, a new input SHALL be written to the skid entry.
REQ-019 When the output is consumed and the skid entry is full, the skid entry SHALL move to the output register in the same edge, and the skid SHALL become empty.
REQ-020 Simultaneous accept and consume with the skid empty: the output register SHALL load the new entry and out_valid SHALL stay 1.
REQ-021 Order SHALL be strictly FIFO. No entry is lost or duplicated.
REQ-022 out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Decode uses opcode in_instr[6:0] and is computed before registering:
- I (0010011, 0000011, 1100111, 1110011): sext(instr[31:20])
- S (0100011): sext({instr[31:25], instr[11:7]})
- B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
- U (0110111, 0010111): {instr[31:12], 12'b0}
- J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
REQ-024 Sign extension SHALL replicate instr[31] into all upper bits; the 12-bit I/S fields SHALL use 12-to-32 sign extension.
REQ-025 Any other opcode: out_imm=0, out_fmt=7, out_illegal=1. The entry SHALL still flow through the handshake normally.
REQ-026 flush=1: at the next edge both entries SHALL be cleared, out_valid=0 and the skid empty; an input presented in the flush cycle is not accepted.
REQ-027 flush SHALL take priority over accept and consume in the same cycle.

Reset
REQ-028 While rst_n=0, the following SHALL hold immediately (asynchronously):
- out_valid=0, skid empty
- out_instr=0, out_imm=0, out_fmt=0, out_illegal=0
REQ-029 After rst_n deasserts, in_ready SHALL be 1 from the first cycle unless flush=1.
REQ-030 Reset asserted mid-transfer SHALL drop all held entries; none is delivered after reset.

Verification
REQ-031 I-type sign extension: in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=0, out_illegal=0.
REQ-032 S-type: in_instr=0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, out_fmt=1.
REQ-033 U-type: in_instr=0x123452B7 (lui x5,0x12345) -> out_imm=0x12345000, out_fmt=3.
REQ-034 Backpressure sequence:
- out_ready=0; send A=0xFFF00093 then B=0x123452B7 on back-to-back cycles -> in_ready=0 after B is accepted.
- out_ready=1 -> A then B appear on consecutive cycles, after which in_ready=1.
REQ-035 Flush while full: flush=1 with both entries held -> next cycle out_valid=0, in_ready=1, and no further outputs appear.
REQ-036 Illegal opcode and reset:
- in_instr=0x0000007F -> out_illegal=1, out_imm=0, out_fmt=7.
- rst_n pulsed low while out_valid=1 -> out_valid=0 immediately.
